// File: rtl/cache_ctrl.sv
// Direct-mapped cache controller: owns valid/dirty/tag per set, drives an external data array
// and a line-transfer memory port. Optional counters via CACHE_CTRL_STATS_EN.
module cache_ctrl #(
    parameter int SETS_LOG2 = 10,
    parameter int TAG_W     = 3,
    parameter int OFFSET_W  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cpu_req,
    input  logic                          cpu_we,
    input  logic [TAG_W+SETS_LOG2+OFFSET_W-1:0] cpu_addr,
    output logic                          cpu_ready,
    output logic                          cpu_hit,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [TAG_W+SETS_LOG2-1:0]    mem_line_addr,
    input  logic                          mem_ack,
    output logic [SETS_LOG2-1:0]          dary_set,
    output logic                          dary_fill,
    output logic                          dary_word_we,
    output logic [2:0]                    dbgState,
    output logic [OFFSET_W-1:0]           dbgOffset
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [15:0]                   hit_cnt,
    output logic [15:0]                   miss_cnt,
    output logic [15:0]                   wb_cnt
`endif
);
    localparam int ADDR_W = TAG_W + SETS_LOG2 + OFFSET_W;
    localparam int SETS   = 1 << SETS_LOG2;

    // Memory handshake: mem_req/mem_we/mem_line_addr stay constant from the first request
    // cycle through the cycle mem_ack=1; mem_ack outside mem_req is ignored.
    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;

    state_t state, nextState;
    logic [ADDR_W-1:0]   reqAddr;
    logic                reqWe;
    logic                hitReg;
    logic [SETS-1:0]     validBits;
    logic [SETS-1:0]     dirtyBits;
    logic [TAG_W-1:0]    tagMem [SETS];

    logic [TAG_W-1:0]     reqTag;
    logic [SETS_LOG2-1:0] reqSet;
    logic [TAG_W-1:0]     storedTag;
    logic                 lookupHit;

    assign reqTag    = reqAddr[ADDR_W-1 -: TAG_W];
    assign reqSet    = reqAddr[OFFSET_W +: SETS_LOG2];
    assign storedTag = tagMem[reqSet];
    assign lookupHit = validBits[reqSet] && (storedTag == reqTag);
    assign dary_set  = reqSet;
    assign dbgState  = state;
    assign dbgOffset = reqAddr[OFFSET_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            reqAddr   <= '0;
            reqWe     <= 1'b0;
            hitReg    <= 1'b0;
            validBits <= '0;
            dirtyBits <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE && cpu_req) begin
                reqAddr <= cpu_addr;
                reqWe   <= cpu_we;
            end
            if (state == LOOKUP)
                hitReg <= lookupHit;
            if (dary_fill) begin
                validBits[reqSet] <= 1'b1;
                dirtyBits[reqSet] <= 1'b0;
            end
            if (dary_word_we)
                dirtyBits[reqSet] <= 1'b1;
        end
    end

    // Tags survive reset; the cleared valid bits make stale tags harmless.
    always_ff @(posedge clk) begin
        if (dary_fill)
            tagMem[reqSet] <= reqTag;
    end

    always_comb begin
        nextState     = state;
        cpu_ready     = 1'b0;
        cpu_hit       = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_line_addr = reqAddr[ADDR_W-1:OFFSET_W];
        dary_fill     = 1'b0;
        dary_word_we  = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req)
                    nextState = LOOKUP;
            end
            LOOKUP: begin
                if (lookupHit)
                    nextState = RESPOND;
                else if (validBits[reqSet] && dirtyBits[reqSet])
                    nextState = WRITEBACK;
                else
                    nextState = REFILL;
            end
            WRITEBACK: begin
                mem_req       = 1'b1;
                mem_we        = 1'b1;
                mem_line_addr = {storedTag, reqSet};
                if (mem_ack)
                    nextState = REFILL;
            end
            REFILL: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    dary_fill = 1'b1;
                    nextState = RESPOND;
                end
            end
            RESPOND: begin
                cpu_ready    = 1'b1;
                cpu_hit      = hitReg;
                dary_word_we = reqWe;
                nextState    = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

`ifdef CACHE_CTRL_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            if (state == RESPOND) begin
                if (hitReg) begin
                    if (hit_cnt != 16'hFFFF)
                        hit_cnt <= hit_cnt + 16'd1;
                end else if (miss_cnt != 16'hFFFF) begin
                    miss_cnt <= miss_cnt + 16'd1;
                end
            end
            if (state == WRITEBACK && mem_ack && wb_cnt != 16'hFFFF)
                wb_cnt <= wb_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: transaction-level cache model expands each access into a per-cycle
// expected output script; one negedge process compares it. Set CACHE_CTRL_STATS_EN for counters.
module tb_cache_ctrl;
    localparam int EW = 33;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [16:0] cpu_addr = '0;
    logic        mem_ack = 1'b0;
    logic        cpu_ready, cpu_hit, mem_req, mem_we, dary_fill, dary_word_we;
    logic [12:0] mem_line_addr;
    logic [9:0]  dary_set;
    logic [2:0]  dbgState;
    logic [3:0]  dbgOffset;
`ifdef CACHE_CTRL_STATS_EN
    logic [15:0] hit_cnt, miss_cnt, wb_cnt;
`endif

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_ready(cpu_ready), .cpu_hit(cpu_hit), .mem_req(mem_req), .mem_we(mem_we),
        .mem_line_addr(mem_line_addr), .mem_ack(mem_ack), .dary_set(dary_set),
        .dary_fill(dary_fill), .dary_word_we(dary_word_we), .dbgState(dbgState),
        .dbgOffset(dbgOffset)
`ifdef CACHE_CTRL_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
    );

    int n_cmp = 0;
    int n_fail = 0;
    logic [EW-1:0] exp_q[$];

    // cache model
    bit          m_valid [1024];
    bit          m_dirty [1024];
    logic [2:0]  m_tag   [1024];
    int          m_hits, m_miss, m_wbs;

    // observations for literal checks
    logic [12:0] obs_rf_line, obs_wb_line;
    int          obs_fills, obs_ready, obs_memcyc;
    logic        obs_hit;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] mk(input bit rdy, input bit hit, input bit mreq, input bit mwe,
                                         input bit fill, input bit wwe, input logic [12:0] line,
                                         input logic [9:0] set, input logic [3:0] off);
        return {rdy, hit, mreq, mwe, fill, wwe, line, set, off};
    endfunction

    function automatic logic nz();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hits = 0;
        m_miss = 0;
        m_wbs  = 0;
    endtask

    task automatic clear_obs();
        obs_rf_line = '0;
        obs_wb_line = '0;
        obs_fills   = 0;
        obs_ready   = 0;
        obs_memcyc  = 0;
        obs_hit     = 1'bx;
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] e, g, m;
        e = '0;
        if (exp_q.size() > 0)
            e = exp_q.pop_front();
        g = {cpu_ready, cpu_hit, mem_req, mem_we, dary_fill, dary_word_we,
             mem_line_addr, dary_set, dbgOffset};
        m = {6'b111111, {13{e[30]}}, {10{e[28] | e[27]}}, {4{e[27]}}};
        check("cycle_outputs", 64'(g & m), 64'(e & m));
        if (mem_req) begin
            obs_memcyc++;
            if (mem_we) obs_wb_line = mem_line_addr;
            else        obs_rf_line = mem_line_addr;
        end
        if (dary_fill) obs_fills++;
        if (cpu_ready) begin
            obs_ready++;
            obs_hit = cpu_hit;
        end
    end

    // One access: expand the model's prediction into a cycle script, then play it.
    // Called at the start of a cycle (just after a rising edge).
    task automatic run_access(input logic [16:0] addr, input logic we, input int d_rf_fix,
                              input bit inject, input int abort_after);
        logic [2:0]  t;
        logic [9:0]  s;
        logic [3:0]  off;
        bit          hit, wb;
        logic [12:0] wb_line;
        int          d_wb, d_rf;
        logic [EW-1:0] se[$];
        logic [1:0]    si[$];
        bit          aborted;
        t = addr[16:14];
        s = addr[13:4];
        off = addr[3:0];
        hit = m_valid[s] && (m_tag[s] == t);
        wb = !hit && m_valid[s] && m_dirty[s];
        wb_line = {m_tag[s], s};
        d_wb = $urandom_range(0, 3);
        d_rf = (d_rf_fix >= 0) ? d_rf_fix : $urandom_range(0, 3);

        se.push_back('0); si.push_back({1'b1, nz()});
        se.push_back('0); si.push_back({nz(), nz()});
        if (wb)
            for (int i = 0; i <= d_wb; i++) begin
                se.push_back(mk(0, 0, 1, 1, 0, 0, wb_line, '0, '0));
                si.push_back({inject ? 1'b1 : nz(), 1'(i == d_wb)});
            end
        if (!hit)
            for (int i = 0; i <= d_rf; i++) begin
                se.push_back(mk(0, 0, 1, 0, i == d_rf, 0, {t, s}, s, '0));
                si.push_back({nz(), 1'(i == d_rf)});
            end
        se.push_back(mk(1, hit, 0, 0, 0, we, '0, s, off));
        si.push_back({nz(), nz()});

        aborted = 1'b0;
        for (int k = 0; k < se.size(); k++) begin
            if (abort_after >= 0 && k >= abort_after) begin
                aborted = 1'b1;
                break;
            end
            {cpu_req, mem_ack} = si[k];
            if (k == 0) begin
                cpu_addr = addr;
                cpu_we   = we;
            end else begin
                cpu_addr = 17'($urandom);
                cpu_we   = 1'($urandom);
            end
            exp_q.push_back(se[k]);
            @(posedge clk);
            #1;
        end
        cpu_req = 1'b0;
        mem_ack = 1'b0;
        if (!aborted) begin
            if (hit) m_hits++;
            else     m_miss++;
            if (wb)  m_wbs++;
            if (!hit) begin
                m_tag[s]   = t;
                m_valid[s] = 1'b1;
                m_dirty[s] = 1'b0;
            end
            if (we) m_dirty[s] = 1'b1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [16:0] a;
        model_reset();
        clear_obs();
        repeat (3) @(posedge clk);
        #1;
        check("reset_cpu_ready", 64'(cpu_ready), 64'd0);
        check("reset_mem_req", 64'(mem_req), 64'd0);
        check("reset_dary_fill", 64'(dary_fill), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // read 128: refill of line 8 with ack three cycles after mem_req
        clear_obs();
        run_access(17'd128, 1'b0, 3, 1'b0, -1);
        check("rd128_refill_line", 64'(obs_rf_line), 64'd8);
        check("rd128_fill_count", 64'(obs_fills), 64'd1);
        check("rd128_mem_cycles", 64'(obs_memcyc), 64'd4);
        check("rd128_hit", 64'(obs_hit), 64'd0);

        // write 128: hit, no memory traffic
        clear_obs();
        run_access(17'd128, 1'b1, -1, 1'b0, -1);
        check("wr128_hit", 64'(obs_hit), 64'd1);
        check("wr128_mem_cycles", 64'(obs_memcyc), 64'd0);
        check("wr128_ready_count", 64'(obs_ready), 64'd1);

        // read 16512: dirty conflict in set 8, cpu_req held during writeback
        clear_obs();
        run_access(17'd16512, 1'b0, -1, 1'b1, -1);
        check("rd16512_wb_line", 64'(obs_wb_line), 64'd8);
        check("rd16512_refill_line", 64'(obs_rf_line), 64'd1032);
        check("rd16512_hit", 64'(obs_hit), 64'd0);
        check("rd16512_ready_count", 64'(obs_ready), 64'd1);

        clear_obs();
        run_access(17'd16512, 1'b0, -1, 1'b0, -1);
        check("rd16512_again_hit", 64'(obs_hit), 64'd1);
        check("rd16512_again_mem", 64'(obs_memcyc), 64'd0);
`ifdef CACHE_CTRL_STATS_EN
        check("stats_hit_cnt", 64'(hit_cnt), 64'd2);
        check("stats_miss_cnt", 64'(miss_cnt), 64'd2);
        check("stats_wb_cnt", 64'(wb_cnt), 64'd1);
`endif

        // reset in the middle of a refill of 128 (set 8 holds clean tag 1)
        clear_obs();
        run_access(17'd128, 1'b0, 3, 1'b0, 4);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("rstmid_mem_req", 64'(mem_req), 64'd0);
        check("rstmid_cpu_ready", 64'(cpu_ready), 64'd0);
        check("rstmid_dary_fill", 64'(dary_fill), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_no_ready", 64'(obs_ready), 64'd0);
        check("rstmid_no_fill", 64'(obs_fills), 64'd0);
        clear_obs();
        run_access(17'd128, 1'b0, -1, 1'b0, -1);
        check("after_rst_rd128_hit", 64'(obs_hit), 64'd0);
        check("after_rst_refill_line", 64'(obs_rf_line), 64'd8);

        // randomized traffic over a few contended sets
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0:       a[13:4] = 10'd8;
                1:       a[13:4] = 10'd1023;
                2:       a[13:4] = 10'd0;
                default: a[13:4] = 10'($urandom_range(0, 3));
            endcase
            a[16:14] = 3'($urandom_range(0, 2));
            a[3:0]   = 4'($urandom_range(0, 15));
            run_access(a, nz(), -1, $urandom_range(0, 3) == 0, -1);
            repeat ($urandom_range(0, 2)) begin
                mem_ack = nz();
                @(posedge clk);
                #1;
            end
            mem_ack = 1'b0;
        end
        @(posedge clk);
        #1;
`ifdef CACHE_CTRL_STATS_EN
        check("final_hit_cnt", 64'(hit_cnt), 64'(m_hits));
        check("final_miss_cnt", 64'(miss_cnt), 64'(m_miss));
        check("final_wb_cnt", 64'(wb_cnt), 64'(m_wbs));
`endif
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameter SETS_LOG2, default 10: set-index width; the block has 1024 sets.
REQ-002 Parameter TAG_W, default 3: tag width.
REQ-003 Parameter OFFSET_W, default 4: word-offset width; a line is 16 words of 32 bits.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cpu_req  in  1  access request, sampled only in IDLE.
REQ-007 cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req.
REQ-008 cpu_addr  in  17  word address: [16:14] tag, [13:4] set, [3:0] offset.
REQ-009 cpu_ready  out  1  one-cycle completion pulse.
REQ-010 cpu_hit  out  1  valid with cpu_ready: 1 = hit, 0 = miss.
REQ-011 mem_req  out  1  memory line-transfer request.
REQ-012 mem_we  out  1  1 = writeback, 0 = refill; valid while mem_req=1.
REQ-013 mem_line_addr  out  13  line address {tag,set}.
REQ-014 mem_ack  in  1  memory done; ignored while mem_req=0.
REQ-015 dary_set  out  10  data-array set index, equal to the latched cpu_addr[13:4].
REQ-016 dary_fill  out  1  pulse that loads the memory read line into data-array set dary_set.
REQ-017 dary_word_we  out  1  pulse that writes the CPU word at the latched offset.

Function
REQ-018 The block owns per-set valid, dirty and tag storage; data storage is external.
REQ-019 States: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
REQ-020 In IDLE, cpu_req=1 latches cpu_addr and cpu_we and moves to LOOKUP; requests in any other state are ignored.
REQ-021 LOOKUP: hit = valid && stored tag == latched tag. Hit goes to RESPOND. Miss with valid&&dirty goes to WRITEBACK. Other misses go to REFILL.
REQ-022 WRITEBACK: mem_req=1, mem_we=1, mem_line_addr = {stored tag, set}, all held stable until the cycle mem_ack=1, then REFILL.
REQ-023 REFILL: mem_req=1, mem_we=0, mem_line_addr = latched cpu_addr[16:4], until mem_ack=1.
REQ-024 In the REFILL mem_ack cycle: dary_fill=1, tag := latched tag, valid := 1, dirty := 0; next state RESPOND.
REQ-025 RESPOND lasts one cycle: cpu_ready=1 and cpu_hit = the LOOKUP result. If latched we=1, dary_word_we=1 and dirty := 1. Next state IDLE.
REQ-026 Hit latency: request accepted at edge N, cpu_ready high in cycle N+2.
REQ-027 Clean-miss latency: cpu_ready is high the cycle after the refill ack; a dirty miss adds the writeback handshake first.
REQ-028 mem_ack in the first cycle of mem_req is legal and completes that transfer.
REQ-029 Outputs are 0 in every state except where stated above; mem_line_addr and dary_set are don't-care while inactive.
REQ-030 A request to the same line immediately after a miss completes as a hit.

Reset
REQ-031 rst=1 forces IDLE immediately and clears all valid and dirty bits; tags are not cleared.
REQ-032 During reset, cpu_ready, cpu_hit, mem_req, mem_we, dary_fill and dary_word_we are 0.
REQ-033 Reset during WRITEBACK or REFILL drops mem_req immediately, with no completion pulse; a later mem_ack is ignored.

Configuration
REQ-034 Macro CACHE_CTRL_STATS_EN, when defined, adds outputs hit_cnt (16) and miss_cnt (16) and wb_cnt (16).
REQ-035 With CACHE_CTRL_STATS_EN, the counters increment in RESPOND (hit or miss) and on the writeback ack, saturate at 16'hFFFF, and reset to 0.
REQ-036 Without CACHE_CTRL_STATS_EN, these ports and counters do not exist, and the behaviour in REQ-018 to REQ-033 is unchanged.

Verification
REQ-037 After reset, read addr 128 with mem_ack 3 cycles after mem_req -> one REFILL at line 8, dary_fill pulse, cpu_ready with cpu_hit=0.
REQ-038 Then write addr 128 -> cpu_ready 2 cycles after acceptance, cpu_hit=1, dary_word_we=1, no mem_req.
REQ-039 Then read addr 16512 (tag 1, set 8) -> WRITEBACK to line 8 (mem_we=1), then REFILL of line 1032, cpu_hit=0; a second read of 16512 -> hit.
REQ-040 Assert rst mid-REFILL, then pulse mem_ack -> no cpu_ready or dary_fill; a read of 128 then misses.
REQ-041 Pulse cpu_req during WRITEBACK -> ignored; with CACHE_CTRL_STATS_EN, after REQ-037 to REQ-039: hit_cnt=2, miss_cnt=2, wb_cnt=1.
